// File: rtl/ap_seq_pkg.sv
// ap_seq_pkg -- shared types and constants for the associative-processor
// operation sequencer (ap_seq) and its pass lookup (ap_seq_lut).
//
// Contents:
//   state_e            sequencer FSM states
//   OP_ADD / OP_SUB    command op codes
//   N_PASSES, PASS_W   compare/write passes per operand bit
//   ADD_KEY / ADD_VAL  ADD pass keys (c,b,a) and write values (c',b')
//   SUB_KEY / SUB_VAL  SUB (borrow) pass keys and write values
//
// Optional feature macro: AP_SEQ_SUB_EN (the SUB tables are only consumed
// when it is defined).

package ap_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_CLR   = 3'd2,
        S_CMP   = 3'd3,
        S_WR    = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int N_PASSES = 4;
    localparam int PASS_W   = 2;

    // Pass order matters: a row rewritten by one pass must never match a
    // later pass of the same bit.
    // ADD (c,b,a) -> (c',b')
    localparam logic [2:0] ADD_KEY [N_PASSES] = '{3'b011, 3'b001, 3'b100, 3'b110};
    localparam logic [1:0] ADD_VAL [N_PASSES] = '{2'b10,  2'b01,  2'b01,  2'b10};

    // SUB with borrow: B <- B - A - borrow
    localparam logic [2:0] SUB_KEY [N_PASSES] = '{3'b001, 3'b011, 3'b110, 3'b100};
    localparam logic [1:0] SUB_VAL [N_PASSES] = '{2'b11,  2'b00,  2'b00,  2'b11};

endpackage

// File: rtl/ap_seq_lut.sv
// ap_seq_lut -- combinational lookup from (op, pass index) to the CAM
// compare key (c,b,a) and the write value (c',b') of that pass.
//
// Ports:
//   op_i    command op (OP_ADD / OP_SUB)
//   pass_i  pass index within the current bit, 0..N_PASSES-1
//   key_o   3-bit compare key, {carry, b, a}
//   val_o   2-bit write value, {carry', b'}
//
// Optional feature macro: AP_SEQ_SUB_EN. When undefined only the ADD table
// exists and op_i has no effect (the sequencer rejects SUB before any pass).

module ap_seq_lut
    import ap_seq_pkg::*;
(
    input  logic              op_i,
    input  logic [PASS_W-1:0] pass_i,
    output logic [2:0]        key_o,
    output logic [1:0]        val_o
);

`ifdef AP_SEQ_SUB_EN
    always_comb begin
        key_o = ADD_KEY[pass_i];
        val_o = ADD_VAL[pass_i];
        if (op_i == OP_SUB) begin
            key_o = SUB_KEY[pass_i];
            val_o = SUB_VAL[pass_i];
        end
    end
`else
    logic unused_op;
    assign unused_op = op_i;

    always_comb begin
        key_o = ADD_KEY[pass_i];
        val_o = ADD_VAL[pass_i];
    end
`endif

endmodule

// File: rtl/ap_seq.sv
// ap_seq -- bit-serial operation sequencer for the associative-processor CAM.
// Turns one host command into CLR + (CMP, WR) x 4 passes per bit, computing
// B <- B + A (or B - A) in place across every CAM row, using a carry column.
// While idle the host single-word read/write path passes straight through;
// while a command runs host writes are dropped.
//
// Command handshake: start is a one-cycle strobe honoured only while busy is
// low; the command fields are captured on that edge. busy rises the next
// cycle and stays high through the done cycle. done is a one-cycle pulse, and
// err is meaningful only while done is high (1 = command rejected, no CAM
// write performed). start while busy is ignored.
//
// Ports:
//   clock, rst            rising-edge clock, asynchronous active-low reset
//   start, op             command strobe and op (0 ADD, 1 SUB)
//   a_base, b_base, c_pos LSB of A, LSB of B (result), carry column
//   nbits                 operand width
//   busy, done, err       status
//   host_addr/din/we/dout host single-word access
//   cam_*                 CAM control outputs; cam_tags/cam_doutb from CAM
//   dbg_state_o           current FSM state, for observation only
//
// Optional feature macro: AP_SEQ_SUB_EN (enables op = 1; otherwise rejected).

module ap_seq
    import ap_seq_pkg::*;
#(
    parameter int WORD_SIZE  = 8,
    parameter int CELL_QUANT = 512,
    parameter int BIT_W      = $clog2(WORD_SIZE)
) (
    input  logic                          clock,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          op,
    input  logic [BIT_W-1:0]              a_base,
    input  logic [BIT_W-1:0]              b_base,
    input  logic [BIT_W-1:0]              c_pos,
    input  logic [BIT_W:0]                nbits,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    input  logic [$clog2(CELL_QUANT)-1:0] host_addr,
    input  logic [WORD_SIZE-1:0]          host_din,
    input  logic                          host_we,
    output logic [WORD_SIZE-1:0]          host_dout,
    output logic [$clog2(CELL_QUANT)-1:0] cam_addr_in,
    output logic                          cam_mode,
    output logic [CELL_QUANT-1:0]         cam_cell_wea_ctrl_ap,
    output logic                          cam_wea,
    output logic [WORD_SIZE-1:0]          cam_dina,
    output logic [WORD_SIZE-1:0]          cam_key,
    output logic [WORD_SIZE-1:0]          cam_mask,
    output logic                          cam_direction,
    output logic                          cam_internal_col_in,
    input  logic [CELL_QUANT-1:0]         cam_tags,
    input  logic [WORD_SIZE-1:0]          cam_doutb,
    output state_e                        dbg_state_o
);

    localparam logic [BIT_W+1:0] WORD_LIM = (BIT_W+2)'(WORD_SIZE);

    state_e            state_q, state_d;

    // latched command
    logic              op_q, op_d;
    logic [BIT_W-1:0]  a_base_q, a_base_d;
    logic [BIT_W-1:0]  b_base_q, b_base_d;
    logic [BIT_W-1:0]  c_pos_q, c_pos_d;
    logic [BIT_W:0]    nbits_q, nbits_d;

    // loop position: operand bit and pass within the bit
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [PASS_W-1:0] pass_q, pass_d;

    // registered control outputs
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              mode_q, mode_d;
    logic              wea_q, wea_d;
    logic              all_rows_q, all_rows_d;
    logic              tag_rows_q, tag_rows_d;
    logic [WORD_SIZE-1:0] key_q, key_d;
    logic [WORD_SIZE-1:0] mask_q, mask_d;
    logic [WORD_SIZE-1:0] dina_q, dina_d;
    logic [CELL_QUANT-1:0] tag_q;

    logic              illegal;
    logic              sub_reject;
    logic              last_bit;
    logic [BIT_W-1:0]  a_idx, b_idx;
    logic [2:0]        lut_key;
    logic [1:0]        lut_val;

    // ------------------------------------------------------------------
    // Command legality, evaluated on the latched fields during CHECK.
    // Widened by two bits so base + nbits cannot wrap.
    // ------------------------------------------------------------------
    logic [BIT_W+1:0] a_lo, b_lo, c_ext, n_ext, a_hi, b_hi;

    assign a_lo  = {2'b00, a_base_q};
    assign b_lo  = {2'b00, b_base_q};
    assign c_ext = {2'b00, c_pos_q};
    assign n_ext = {1'b0, nbits_q};
    assign a_hi  = a_lo + n_ext;
    assign b_hi  = b_lo + n_ext;

`ifdef AP_SEQ_SUB_EN
    assign sub_reject = 1'b0;
`else
    assign sub_reject = (op_q == OP_SUB);
`endif

    assign illegal = (nbits_q == '0)
                   | (a_hi > WORD_LIM)
                   | (b_hi > WORD_LIM)
                   | ((a_lo < b_hi) && (b_lo < a_hi))
                   | ((c_ext >= a_lo) && (c_ext < a_hi))
                   | ((c_ext >= b_lo) && (c_ext < b_hi))
                   | sub_reject;

    assign last_bit = ({1'b0, bit_q} == (nbits_q - (BIT_W+1)'(1)));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_base_d = a_base_q;
        b_base_d = b_base_q;
        c_pos_d  = c_pos_q;
        nbits_d  = nbits_q;
        bit_d    = bit_q;
        pass_d   = pass_q;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d     = op;
                    a_base_d = a_base;
                    b_base_d = b_base;
                    c_pos_d  = c_pos;
                    nbits_d  = nbits;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (illegal) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                bit_d   = '0;
                pass_d  = '0;
                state_d = S_CMP;
            end
            S_CMP: begin
                state_d = S_WR;
            end
            S_WR: begin
                if (pass_q == PASS_W'(N_PASSES - 1)) begin
                    if (last_bit) begin
                        state_d = S_DONE;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        pass_d  = '0;
                        state_d = S_CMP;
                    end
                end else begin
                    pass_d  = pass_q + PASS_W'(1);
                    state_d = S_CMP;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode. Controls are computed for the state being entered so
    // they can be registered and still line up with that state's cycle.
    // ------------------------------------------------------------------
    assign a_idx = a_base_q + bit_d;
    assign b_idx = b_base_q + bit_d;

    ap_seq_lut u_lut (
        .op_i   (op_q),
        .pass_i (pass_d),
        .key_o  (lut_key),
        .val_o  (lut_val)
    );

    always_comb begin
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        mode_d     = (state_d == S_CLR) || (state_d == S_WR);
        wea_d      = (state_d == S_CLR) || (state_d == S_WR);
        all_rows_d = (state_d == S_CLR);
        tag_rows_d = (state_d == S_WR);
        key_d      = '0;
        mask_d     = '0;
        dina_d     = '0;

        case (state_d)
            S_CLR: begin
                mask_d[c_pos_q] = 1'b1;
            end
            S_CMP: begin
                mask_d[c_pos_q] = 1'b1;
                mask_d[b_idx]   = 1'b1;
                mask_d[a_idx]   = 1'b1;
                key_d[c_pos_q]  = lut_key[2];
                key_d[b_idx]    = lut_key[1];
                key_d[a_idx]    = lut_key[0];
            end
            S_WR: begin
                mask_d[c_pos_q] = 1'b1;
                mask_d[b_idx]   = 1'b1;
                dina_d[c_pos_q] = lut_val[1];
                dina_d[b_idx]   = lut_val[0];
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            op_q       <= OP_ADD;
            a_base_q   <= '0;
            b_base_q   <= '0;
            c_pos_q    <= '0;
            nbits_q    <= '0;
            bit_q      <= '0;
            pass_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            mode_q     <= 1'b0;
            wea_q      <= 1'b0;
            all_rows_q <= 1'b0;
            tag_rows_q <= 1'b0;
            key_q      <= '0;
            mask_q     <= '0;
            dina_q     <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_base_q   <= a_base_d;
            b_base_q   <= b_base_d;
            c_pos_q    <= c_pos_d;
            nbits_q    <= nbits_d;
            bit_q      <= bit_d;
            pass_q     <= pass_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            mode_q     <= mode_d;
            wea_q      <= wea_d;
            all_rows_q <= all_rows_d;
            tag_rows_q <= tag_rows_d;
            key_q      <= key_d;
            mask_q     <= mask_d;
            dina_q     <= dina_d;
        end
    end

    // Match vector captured at the end of each CMP; it becomes the row
    // write-enable set for the following WR.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            tag_q <= '0;
        end else if (state_q == S_CMP) begin
            tag_q <= cam_tags;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;

    // Host write path is live only in IDLE; elsewhere host_we is dropped.
    assign cam_wea     = (state_q == S_IDLE) ? host_we  : wea_q;
    assign cam_dina    = (state_q == S_IDLE) ? host_din : dina_q;
    assign cam_addr_in = host_addr;
    assign host_dout   = cam_doutb;

    assign cam_mode = mode_q;
    assign cam_key  = key_q;
    assign cam_mask = mask_q;

    // CLR writes every row, WR writes the rows that matched the last CMP.
    assign cam_cell_wea_ctrl_ap = all_rows_q ? {CELL_QUANT{1'b1}}
                                : (tag_rows_q ? tag_q : {CELL_QUANT{1'b0}});

    assign cam_direction       = 1'b0;
    assign cam_internal_col_in = 1'b0;
    assign dbg_state_o         = state_q;

endmodule

// File: tb/tb_ap_seq.sv
// tb_ap_seq -- self-checking bench for ap_seq with a behavioural CAM model.
// Expected results come from an arithmetic reference of the word layout,
// pushed to a queue when each command is issued and popped at done.

module tb_ap_seq;
    import ap_seq_pkg::*;

    localparam int WS = 8;
    localparam int CQ = 512;
    localparam int BW = 3;
    localparam int AW = 9;
    localparam int W  = 32;

    logic           clock;
    logic           rst;
    logic           start;
    logic           op;
    logic [BW-1:0]  a_base, b_base, c_pos;
    logic [BW:0]    nbits;
    logic           busy, done, err;
    logic [AW-1:0]  host_addr;
    logic [WS-1:0]  host_din;
    logic           host_we;
    logic [WS-1:0]  host_dout;
    logic [AW-1:0]  cam_addr_in;
    logic           cam_mode;
    logic [CQ-1:0]  cam_cell_wea_ctrl_ap;
    logic           cam_wea;
    logic [WS-1:0]  cam_dina, cam_key, cam_mask;
    logic           cam_direction, cam_internal_col_in;
    logic [CQ-1:0]  cam_tags;
    logic [WS-1:0]  cam_doutb;
    state_e         dbg_state;

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    ap_seq #(.WORD_SIZE(WS), .CELL_QUANT(CQ)) dut (
        .clock                (clock),
        .rst                  (rst),
        .start                (start),
        .op                   (op),
        .a_base               (a_base),
        .b_base               (b_base),
        .c_pos                (c_pos),
        .nbits                (nbits),
        .busy                 (busy),
        .done                 (done),
        .err                  (err),
        .host_addr            (host_addr),
        .host_din             (host_din),
        .host_we              (host_we),
        .host_dout            (host_dout),
        .cam_addr_in          (cam_addr_in),
        .cam_mode             (cam_mode),
        .cam_cell_wea_ctrl_ap (cam_cell_wea_ctrl_ap),
        .cam_wea              (cam_wea),
        .cam_dina             (cam_dina),
        .cam_key              (cam_key),
        .cam_mask             (cam_mask),
        .cam_direction        (cam_direction),
        .cam_internal_col_in  (cam_internal_col_in),
        .cam_tags             (cam_tags),
        .cam_doutb            (cam_doutb),
        .dbg_state_o          (dbg_state)
    );

    // ---------------- CAM model ----------------
    logic [WS-1:0] mem [CQ];
    logic          fill_req;
    logic [WS-1:0] fill_val;

    always @(posedge clock) begin
        if (fill_req) begin
            for (int r = 0; r < CQ; r++) mem[r] <= fill_val;
        end else if (cam_wea) begin
            if (!cam_mode) begin
                mem[cam_addr_in] <= cam_dina;
            end else begin
                for (int r = 0; r < CQ; r++)
                    if (cam_cell_wea_ctrl_ap[r])
                        mem[r] <= (mem[r] & ~cam_mask) | (cam_dina & cam_mask);
            end
        end
    end

    always_comb begin
        for (int r = 0; r < CQ; r++)
            cam_tags[r] = (((mem[r] ^ cam_key) & cam_mask) == '0);
    end

    assign cam_doutb = mem[cam_addr_in];

    // ---------------- scoreboard ----------------
    logic [WS-1:0] ref_mem [CQ];
    logic [W-1:0]  exp_q[$];
    int            n_vec;
    int            n_bad;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: B field replaced by (B + A) or (B - A), carry column gets
    // the carry-out / final borrow; every other bit untouched.
    function automatic logic [WS-1:0] ref_word(input logic [WS-1:0] v, input logic sub,
                                               input int a, input int b, input int c, input int n);
        int mk, av, bv, s;
        logic [WS-1:0] r;
        mk = (1 << n) - 1;
        av = (int'(v) >> a) & mk;
        bv = (int'(v) >> b) & mk;
        r  = v;
        if (!sub) begin
            s    = av + bv;
            r[c] = s[n];
        end else begin
            s    = bv - av;
            r[c] = (bv < av);
        end
        for (int k = 0; k < n; k++) r[b + k] = s[k];
        return r;
    endfunction

    task automatic mem_diff(input string tag);
        int cnt;
        cnt = 0;
        for (int r = 0; r < CQ; r++) if (mem[r] !== ref_mem[r]) cnt++;
        chk(tag, cnt, 0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic fill_mem(input logic [WS-1:0] v);
        @(negedge clock);
        fill_req = 1'b1;
        fill_val = v;
        @(negedge clock);
        fill_req = 1'b0;
        for (int r = 0; r < CQ; r++) ref_mem[r] = v;
    endtask

    task automatic host_write(input int addr, input logic [WS-1:0] d);
        @(negedge clock);
        host_addr = AW'(addr);
        host_din  = d;
        host_we   = 1'b1;
        @(negedge clock);
        host_we   = 1'b0;
        ref_mem[addr] = d;
    endtask

    // Issue one command and follow it to done. probe adds CLR/first-CMP
    // control checks (ADD only); hold_we drives a host write all the way
    // through the busy window.
    task automatic run_cmd(input logic sub, input int a, input int b, input int c, input int n,
                           input logic exp_err, input logic probe, input logic hold_we);
        int got_cyc;
        int wea_cnt;
        logic got_err;
        logic busy_at_done;

        exp_q.push_back(exp_err ? 2 : 3 + 8 * n);
        exp_q.push_back(W'(exp_err));
        exp_q.push_back(exp_err ? 0 : 1 + 4 * n);
        if (!exp_err)
            for (int r = 0; r < CQ; r++) ref_mem[r] = ref_word(ref_mem[r], sub, a, b, c, n);
        for (int r = 0; r < 4; r++) exp_q.push_back(W'(ref_mem[r]));

        @(negedge clock);
        op     = sub;
        a_base = BW'(a);
        b_base = BW'(b);
        c_pos  = BW'(c);
        nbits  = (BW+1)'(n);
        start  = 1'b1;

        got_cyc = 0;
        wea_cnt = 0;
        got_err = 1'b0;
        busy_at_done = 1'b0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(negedge clock);
            if (cyc == 1) begin
                start = 1'b0;
                chk("busy_c1", busy, 1);
                if (hold_we) begin
                    host_addr = AW'(9);
                    host_din  = 8'hFF;
                    host_we   = 1'b1;
                end
            end
            if (probe && cyc == 2) begin
                chk("clr_mode", cam_mode, 1);
                chk("clr_mask", cam_mask, W'(1 << c));
                chk("clr_dina", cam_dina, 0);
                chk("clr_allrows", &cam_cell_wea_ctrl_ap, 1);
            end
            if (probe && cyc == 3) begin
                chk("cmp0_key", cam_key, W'((1 << b) | (1 << a)));
                chk("cmp0_mask", cam_mask, W'((1 << c) | (1 << b) | (1 << a)));
                chk("cmp0_wea", cam_wea, 0);
            end
            if (cam_wea) wea_cnt++;
            if (done) begin
                got_cyc = cyc;
                got_err = err;
                busy_at_done = busy;
                break;
            end
        end
        host_we = 1'b0;
        if (got_cyc == 0) chk("done_timeout", 0, 1);

        chk("done_cycle", got_cyc, exp_q.pop_front());
        chk("err", got_err, exp_q.pop_front());
        chk("wea_cycles", wea_cnt, exp_q.pop_front());
        chk("busy_at_done", busy_at_done, 1);

        @(negedge clock);
        chk("idle_after", {busy, done, err}, 0);
        for (int r = 0; r < 4; r++) chk($sformatf("row%0d", r), mem[r], exp_q.pop_front());
        mem_diff("mem_all");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_vec     = 0;
        n_bad     = 0;
        rst       = 1'b0;
        start     = 1'b0;
        op        = 1'b0;
        a_base    = '0;
        b_base    = '0;
        c_pos     = '0;
        nbits     = '0;
        host_addr = '0;
        host_din  = '0;
        host_we   = 1'b0;
        fill_req  = 1'b0;
        fill_val  = '0;

        repeat (3) @(negedge clock);
        chk("rst_state", W'(dbg_state), W'(S_IDLE));
        chk("rst_status", {busy, done, err}, 0);
        chk("rst_mode_wea", {cam_mode, cam_wea}, 0);
        chk("rst_rows", |cam_cell_wea_ctrl_ap, 0);
        chk("rst_key", cam_key, 0);
        chk("rst_mask", cam_mask, 0);
        chk("rst_dina", cam_dina, 0);
        chk("const_outs", {cam_direction, cam_internal_col_in}, 0);
        rst = 1'b1;
        @(negedge clock);

        // ADD basic
        fill_mem(8'h00);
        host_write(0, 8'h2B);
        host_write(1, 8'h11);
        run_cmd(1'b0, 0, 3, 7, 3, 1'b0, 1'b1, 1'b0);
        chk("add_row0_const", mem[0], 8'h83);
        chk("add_row1_const", mem[1], 8'h19);

        // carry column cleared before the first bit
        fill_mem(8'h80);
        run_cmd(1'b0, 0, 3, 7, 3, 1'b0, 1'b1, 1'b0);
        chk("carry_clr_row5", mem[5], 8'h00);

        // illegal commands: carry inside B, nbits 0, range past word, overlap, carry inside A
        fill_mem(8'h00);
        host_write(0, 8'h2B);
        run_cmd(1'b0, 0, 3, 4, 3, 1'b1, 1'b0, 1'b0);
        run_cmd(1'b0, 0, 3, 7, 0, 1'b1, 1'b0, 1'b0);
        run_cmd(1'b0, 6, 0, 4, 3, 1'b1, 1'b0, 1'b0);
        run_cmd(1'b0, 0, 2, 7, 3, 1'b1, 1'b0, 1'b0);
        run_cmd(1'b0, 0, 3, 1, 3, 1'b1, 1'b0, 1'b0);
        chk("illegal_row0", mem[0], 8'h2B);

        // host writes blocked while busy, live again once idle
        run_cmd(1'b0, 0, 3, 7, 3, 1'b0, 1'b0, 1'b1);
        chk("blocked_row9", mem[9], 8'h00);
        host_write(9, 8'h5A);
        host_addr = AW'(9);
        @(negedge clock);
        chk("host_readback", host_dout, 8'h5A);

        // SUB
        fill_mem(8'h00);
        host_write(0, 8'h2B);
`ifdef AP_SEQ_SUB_EN
        run_cmd(1'b1, 0, 3, 7, 3, 1'b0, 1'b0, 1'b0);
        chk("sub_row0_const", mem[0], 8'h13);
`else
        run_cmd(1'b1, 0, 3, 7, 3, 1'b1, 1'b0, 1'b0);
        chk("sub_row0_const", mem[0], 8'h2B);
`endif

        // reset in cycle 10 (a WR cycle)
        fill_mem(8'h00);
        host_write(0, 8'h2B);
        @(negedge clock);
        op = 1'b0; a_base = 3'd0; b_base = 3'd3; c_pos = 3'd7; nbits = 4'd3;
        start = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clock);
            if (cyc == 1) start = 1'b0;
        end
        chk("pre_rst_wea", cam_wea, 1);
        rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_wea", cam_wea, 0);
        chk("abort_rows", |cam_cell_wea_ctrl_ap, 0);
        chk("abort_state", W'(dbg_state), W'(S_IDLE));
        @(negedge clock);
        rst = 1'b1;
        fill_mem(8'h00);
        host_write(0, 8'h2B);
        host_write(1, 8'h11);
        run_cmd(1'b0, 0, 3, 7, 3, 1'b0, 1'b1, 1'b0);

        // random data over a few legal layouts
        for (int t = 0; t < 4; t++) begin
            int lay, n;
            logic sub;
            lay = $urandom_range(0, 2);
            n   = $urandom_range(1, 3);
`ifdef AP_SEQ_SUB_EN
            sub = 1'($urandom_range(0, 1));
`else
            sub = 1'b0;
`endif
            fill_mem(8'h00);
            for (int r = 0; r < 8; r++) host_write(r, 8'($urandom_range(0, 255)));
            case (lay)
                0:       run_cmd(sub, 0, 3, 7, n, 1'b0, 1'b0, 1'b0);
                1:       run_cmd(sub, 4, 0, 7, n, 1'b0, 1'b0, 1'b0);
                default: run_cmd(sub, 5, 1, 0, n, 1'b0, 1'b0, 1'b0);
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
